shift_deserializer: RTL
=======================

SHIFT_DESERIALIZER -- requirements
Module: shift_deserializer

Interface
REQ-001 The block SHALL have parameter TO, default 3, meaning the parallel output word width in bits (legal range TO >= 2).
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1, synchronous active-high reset sampled on rising clk.
REQ-004 The block SHALL have port data_i, input, 1, serial bit, MSB of each word first.
REQ-005 The block SHALL have port valid_i, input, 1, data_i carries a valid bit this cycle; no backpressure on the serial side.
REQ-006 The block SHALL have port data_o, output, TO, assembled parallel word.
REQ-007 The block SHALL have port valid_o, output, 1, data_o holds an unconsumed word.
REQ-008 The block SHALL have port ready_i, input, 1, downstream accepts data_o when valid_o && ready_i.
REQ-009 The block SHALL have port overflow_o, output, 1, sticky flag: a completed word was dropped.
REQ-010 The block SHALL have port parity_err_o, output, 1, parity status of the word on data_o.

Function
REQ-011 The block SHALL shift data_i into a TO-bit shift register on every cycle with valid_i=1, the new bit entering at bit 0 so that the first received bit ends at bit TO-1.
REQ-012 The block SHALL count received bits in a counter of width $clog2(TO+2); cycles with valid_i=0 SHALL leave the shift register and counter unchanged.
REQ-013 The block SHALL use two states: COLLECT (receiving frame bits) and a holding-register flag FULL (data_o valid); collection continues regardless of FULL.
REQ-014 When the last data bit of a frame is received, the counter SHALL wrap to 0 and the completed word SHALL be written into the output register in that same clock edge, giving valid_o=1 one cycle after the final valid_i.
REQ-015 valid_o SHALL stay 1 and data_o SHALL stay stable until a cycle with ready_i=1; valid_o SHALL clear on that edge unless a new word completes on the same edge.
REQ-016 If a word completes on the same edge as a handshake (valid_o && ready_i), the new word SHALL load and valid_o SHALL remain 1 without a gap.
REQ-017 If a word completes while valid_o=1 and ready_i=0, the new word SHALL be discarded, data_o SHALL keep the old word, and overflow_o SHALL set and remain 1 until reset.
REQ-018 ready_i while valid_o=0 SHALL have no effect.
REQ-019 data_o SHALL come directly from a register (no combinational path from data_i or ready_i to data_o or valid_o).

Reset
REQ-020 On reset=1 at a clock edge, the shift register, counter, data_o, valid_o, overflow_o and parity_err_o SHALL all become 0.
REQ-021 Reset mid-frame SHALL discard all partially received bits; the first valid_i bit after reset deasserts SHALL be treated as the MSB of a new frame.
REQ-022 Reset SHALL take priority over valid_i and ready_i in the same cycle.

Configuration
REQ-023 Macro SHIFT_DESERIALIZER_PARITY_EN SHALL control the parity feature; ports are identical in both builds.
REQ-024 With the macro defined, each frame SHALL be TO+1 bits: TO data bits followed by one even-parity bit; the word SHALL complete on the parity bit, and parity_err_o SHALL be 1 for that word when the XOR of data and parity bits is 1, loaded and held with data_o.
REQ-025 With the macro defined, a word with a parity error SHALL still be delivered and SHALL obey REQ-015..REQ-017 unchanged.
REQ-026 Without the macro, each frame SHALL be TO bits and parity_err_o SHALL be constant 0.

Verification (TO=3)
REQ-027 Bits 1,0,1 on 3 consecutive valid_i cycles, ready_i=1 -> data_o=3'b101, valid_o=1 for exactly one cycle, starting the cycle after the 3rd bit.
REQ-028 Bits 1,1,0 with valid_i gaps of 2 idle cycles between bits -> data_o=3'b110 once; idle cycles add no bits.
REQ-029 Word 3'b011 held with ready_i=0, then 3 more bits 1,1,1 -> data_o stays 3'b011, overflow_o=1 and stays 1 after ready_i=1 pulses.
REQ-030 Word 3'b100 pending, ready_i=1 on the same edge the next word 3'b010 completes -> valid_o stays 1, data_o becomes 3'b010, overflow_o=0.
REQ-031 2 bits received, reset=1 for one cycle, then bits 0,0,1 -> data_o=3'b001; nothing emitted before them.
REQ-032 Macro defined, frames 1,0,1,0 then 1,0,1,1 -> data_o=3'b101 with parity_err_o=0, then data_o=3'b101 with parity_err_o=1.

Source files
------------

// File: rtl/shift_deserializer.sv
// Serial-to-parallel deserializer, MSB first, with a single-word holding register.
// Optional even-parity frame bit is enabled by defining SHIFT_DESERIALIZER_PARITY_EN.
module shift_deserializer #(
    parameter int TO = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          data_i,
    input  logic          valid_i,
    output logic [TO-1:0] data_o,
    output logic          valid_o,
    input  logic          ready_i,
    output logic          overflow_o,
    output logic          parity_err_o
);

    localparam int CW = $clog2(TO + 2);
`ifdef SHIFT_DESERIALIZER_PARITY_EN
    localparam int FRAME = TO + 1;
`else
    localparam int FRAME = TO;
`endif
    localparam logic [CW-1:0] LAST = CW'(FRAME - 1);
    localparam logic [CW-1:0] ONE  = CW'(1);

    // Even parity: nonzero result means the data plus parity bit has odd weight.
    function automatic logic even_parity_err(input logic [TO-1:0] word, input logic pbit);
        return (^word) ^ pbit;
    endfunction

    logic [TO-1:0] shift_r;
    logic [CW-1:0] cnt_r;
    logic [TO-1:0] data_r;
    logic          valid_r;
    logic          overflow_r;
    logic          perr_r;

    logic          complete_s;
    logic          load_s;
    logic          drop_s;
    logic [TO-1:0] word_s;
    logic          word_perr_s;

    // Word completion and holding-register decisions for this edge.
    always_comb begin
        complete_s  = valid_i && (cnt_r == LAST);
`ifdef SHIFT_DESERIALIZER_PARITY_EN
        // The final bit of the frame is parity, so the data is already in shift_r.
        word_s      = shift_r;
        word_perr_s = even_parity_err(shift_r, data_i);
`else
        word_s      = {shift_r[TO-2:0], data_i};
        word_perr_s = 1'b0;
`endif
        load_s      = complete_s && (!valid_r || ready_i);
        drop_s      = complete_s && valid_r && !ready_i;
    end

    // Serial collection: shift register and frame bit counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            shift_r <= '0;
            cnt_r   <= '0;
        end else if (valid_i) begin
            shift_r <= {shift_r[TO-2:0], data_i};
            cnt_r   <= complete_s ? '0 : (cnt_r + ONE);
        end
    end

    // Holding register with handshake and sticky overflow.
    always_ff @(posedge clk) begin
        if (reset) begin
            data_r     <= '0;
            valid_r    <= 1'b0;
            overflow_r <= 1'b0;
            perr_r     <= 1'b0;
        end else begin
            if (load_s) begin
                data_r  <= word_s;
                perr_r  <= word_perr_s;
                valid_r <= 1'b1;
            end else if (valid_r && ready_i) begin
                valid_r <= 1'b0;
            end
            if (drop_s) begin
                overflow_r <= 1'b1;
            end
        end
    end

    assign data_o       = data_r;
    assign valid_o      = valid_r;
    assign overflow_o   = overflow_r;
    assign parity_err_o = perr_r;

endmodule
